baud_gen: RTL and testbench
===========================

// Module: baud_gen
// PURPOSE
//  UART baud-rate tick generator. Divides the system clock into a one-cycle
//  pulse at 8x the baud rate (RX oversampling) and one at 1x (TX bit timing).
//  Two rates are selectable at run time: 115200 and 9600 baud.
//  Feeds the UART TX and RX FSMs; it has no data path.
// PARAMETERS
//  CLK_FREQ    100_000_000  system clock frequency, Hz
//  BAUD_FAST   115200       rate when baud_select=1
//  BAUD_SLOW   9600         rate when baud_select=0
//  OVERSAMPLE  8            tick_8x pulses per tick_1x
// PORTS
//  clk          in   1  system clock; all logic is on the rising edge
//  rst          in   1  asynchronous, active-low reset
//  baud_select  in   1  1 = BAUD_FAST, 0 = BAUD_SLOW; synchronous to clk
//  tick_1x      out  1  one-cycle pulse, once per bit period
//  tick_8x      out  1  one-cycle pulse, OVERSAMPLE times per bit period
// BEHAVIOUR
//  - Divisor, computed at elaboration with rounding:
//      DIV = (CLK_FREQ + BAUD*OVERSAMPLE/2) / (BAUD*OVERSAMPLE)
//  - Defaults give DIV_FAST=109 (114679 baud, -0.45%) and
//    DIV_SLOW=1302 (9600.6 baud, +0.01%).
//  - div_cnt is $clog2(max DIV) bits wide (11 bits at defaults).
//    It counts 0..DIV-1 and wraps to 0.
//  - tick_8x is registered. It is 1 for exactly one cycle when div_cnt
//    wraps, so its period is exactly DIV clocks.
//  - os_cnt is $clog2(OVERSAMPLE) bits. It advances on each tick_8x
//    and wraps 7->0.
//  - tick_1x is registered. It is 1 in the same cycle as the tick_8x that
//    wraps os_cnt, so its period is OVERSAMPLE*DIV clocks: 872 fast,
//    10416 slow.
//  - tick_1x never asserts without tick_8x in the same cycle.
//  - Reset (rst=0): div_cnt, os_cnt, tick_1x, tick_8x and the
//    sel_q register go to 0 immediately, without waiting for a clock edge.
//  - Reset release: the first tick_8x is asserted DIV cycles after the
//    first rising edge with rst=1. The first tick_1x follows
//    OVERSAMPLE*DIV cycles after that same edge.
//  - Rate change: sel_q is baud_select registered.
//    - While baud_select != sel_q, div_cnt and os_cnt clear to 0 and both
//      ticks are held at 0 for that cycle.
//    - The new rate's timing restarts from that point.
//    - No truncated or merged pulse is ever produced.
//    - A change issued during reset takes effect at release.
//  - Reset asserted mid-count drops both ticks immediately and aborts the
//    current period.
//  - Outputs are never high for more than one consecutive cycle.
// STRUCTURE
//  - Shared package uart_pkg holds:
//    - CLK_FREQ, BAUD_FAST, BAUD_SLOW and OVERSAMPLE defaults;
//    - function calc_div(clk_freq, baud, os) returning the rounded divisor;
//    - the localparams DIV_FAST and DIV_SLOW.
//  - One natural sub-module: tick_divider. It is a loadable modulo-N
//    counter with a synchronous clear, emitting a one-cycle pulse on wrap.
//    - Instance 1: modulo DIV, mux-selected by sel_q, produces tick_8x.
//    - Instance 2: modulo OVERSAMPLE, enabled by tick_8x, produces tick_1x.
// TESTING
//  1. rst=0 for 100 ns, baud_select=1 -> tick_8x=0 and tick_1x=0
//     throughout.
//  2. Release, run 100 us fast:
//     - tick_8x period 1090 ns and tick_1x period 8720 ns, each 1 cycle
//       wide;
//     - 11 tick_1x and 91 tick_8x pulses;
//     - every tick_1x coincides with the 8th tick_8x.
//  3. baud_select=0, pulse rst low for 20 ns, run 1 ms:
//     - tick_8x period 13.02 us and tick_1x period 104.16 us;
//     - 9 tick_1x pulses, the first at 104.16 us after release.
//  4. Toggle baud_select mid-period with no reset:
//     - no tick in the change cycle;
//     - next tick_8x arrives exactly the new DIV cycles later;
//     - no runt or double pulse.
//  5. Assert rst between clock edges mid-count:
//     - ticks drop immediately;
//     - counters read 0;
//     - after release, timing matches scenario 2.
//  6. Assertions for the whole run:
//     - tick_1x implies tick_8x;
//     - no pulse longer than 1 cycle;
//     - measured periods equal DIV and 8*DIV exactly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART timing constants and the divisor calculation used by baud_gen.
`timescale 1ns / 1ps
package uart_pkg;

    localparam int unsigned DEF_CLK_FREQ   = 100_000_000;
    localparam int unsigned DEF_BAUD_FAST  = 115_200;
    localparam int unsigned DEF_BAUD_SLOW  = 9_600;
    localparam int unsigned DEF_OVERSAMPLE = 8;

    typedef enum logic {
        BAUD_SEL_SLOW = 1'b0,
        BAUD_SEL_FAST = 1'b1
    } baud_sel_e;

    // Clock cycles per oversample tick, rounded to nearest.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud,
                                             input int unsigned os);
        return (clk_freq + (baud * os) / 2) / (baud * os);
    endfunction

    localparam int unsigned DIV_FAST = calc_div(DEF_CLK_FREQ, DEF_BAUD_FAST, DEF_OVERSAMPLE);
    localparam int unsigned DIV_SLOW = calc_div(DEF_CLK_FREQ, DEF_BAUD_SLOW, DEF_OVERSAMPLE);

endpackage

// File: rtl/tick_divider.sv
// Loadable modulo-(last+1) counter with synchronous clear; wrap strobes on the terminal count.
`timescale 1ns / 1ps
module tick_divider #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic         wrap
);

    logic [W-1:0] cnt;

    // A wrap is never reported in a clear cycle, so no pulse escapes a restart.
    assign wrap = en && !clr && (cnt == last);

    // Count 0..last while enabled, return to 0 on clear or after the terminal count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == last) ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/baud_gen.sv
// UART baud tick generator: tick_8x for RX oversampling, tick_1x for TX bit timing.
`timescale 1ns / 1ps
module baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
    parameter int unsigned BAUD_FAST  = DEF_BAUD_FAST,
    parameter int unsigned BAUD_SLOW  = DEF_BAUD_SLOW,
    parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic clk,
    input  logic rst,
    input  logic baud_select,
    output logic tick_1x,
    output logic tick_8x
);

    localparam int unsigned FAST_DIV = calc_div(CLK_FREQ, BAUD_FAST, OVERSAMPLE);
    localparam int unsigned SLOW_DIV = calc_div(CLK_FREQ, BAUD_SLOW, OVERSAMPLE);
    localparam int unsigned MAX_DIV  = (FAST_DIV > SLOW_DIV) ? FAST_DIV : SLOW_DIV;
    localparam int unsigned DIV_W    = $clog2(MAX_DIV);
    localparam int unsigned OS_W     = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0] FAST_LAST = DIV_W'(FAST_DIV - 1);
    localparam logic [DIV_W-1:0] SLOW_LAST = DIV_W'(SLOW_DIV - 1);
    localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);

    baud_sel_e        sel_q;
    logic             run_q;
    logic             restart;
    logic [DIV_W-1:0] div_last;
    logic             div_wrap;
    logic             os_wrap;

    // Registered copy of the rate request; a mismatch marks a rate change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q <= BAUD_SEL_SLOW;
        end else begin
            sel_q <= baud_sel_e'(baud_select);
        end
    end

    // Low only until the first edge after reset, so that edge restarts timing
    // exactly like a rate change and the first tick lands DIV cycles after it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    assign restart  = (baud_sel_e'(baud_select) != sel_q) || !run_q;
    assign div_last = (sel_q == BAUD_SEL_FAST) ? FAST_LAST : SLOW_LAST;

    tick_divider #(
        .W (DIV_W)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (restart),
        .en   (1'b1),
        .last (div_last),
        .wrap (div_wrap)
    );

    // Enabled by the strobe that becomes tick_8x, so tick_1x registers in the same cycle.
    tick_divider #(
        .W (OS_W)
    ) u_os (
        .clk  (clk),
        .rst  (rst),
        .clr  (restart),
        .en   (div_wrap),
        .last (OS_LAST),
        .wrap (os_wrap)
    );

    // Register both ticks from the wrap strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_8x <= 1'b0;
            tick_1x <= 1'b0;
        end else begin
            tick_8x <= div_wrap;
            tick_1x <= os_wrap;
        end
    end

endmodule

// File: tb/tb_baud_gen.sv
// Directed bench for baud_gen at 100 MHz with a cycle-accurate tick reference.
`timescale 1ns / 1ps
module tb_baud_gen;

    localparam int DIV_F = 109;
    localparam int DIV_S = 1302;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic baud_select = 1'b1;
    logic tick_1x;
    logic tick_8x;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference timing state
    int   cyc   = 0;
    int   ref_e = 0;
    logic sel_m = 1'b0;
    logic run_m = 1'b0;

    // Observed pulse statistics
    int     n8 = 0, n1 = 0;
    longint first8 = 0, first1 = 0;
    longint t8_prev = 0, t8_last = 0, t1_prev = 0, t1_last = 0;
    logic   prev8 = 1'b0, prev1 = 1'b0;

    int     n;
    longint t_e1;

    baud_gen dut (
        .clk         (clk),
        .rst         (rst),
        .baud_select (baud_select),
        .tick_1x     (tick_1x),
        .tick_8x     (tick_8x)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        n8 = 0; n1 = 0; first8 = 0; first1 = 0;
        t8_prev = 0; t8_last = 0; t1_prev = 0; t1_last = 0;
    endtask

    // Count rising edges until the chosen tick is seen high (bounded by limit).
    task automatic count_to_tick(input bit want1x, input int limit, output int cnt);
        cnt = 0;
        do begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end while (!(want1x ? tick_1x : tick_8x) && cnt < limit);
    endtask

    // Reference: timing restarts on the first edge after reset and on every rate change.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ref_e = cyc;
            sel_m = 1'b0;
            run_m = 1'b0;
        end else begin
            cyc = cyc + 1;
            if (!run_m || baud_select != sel_m) ref_e = cyc;
            run_m = 1'b1;
            sel_m = baud_select;
        end
    end

    // Whole-run monitor: exact tick positions, tick_1x implies tick_8x, single-cycle width.
    always @(negedge clk) begin : mon
        int   d;
        int   dv;
        logic e8;
        logic e1;
        d  = cyc - ref_e;
        dv = sel_m ? DIV_F : DIV_S;
        e8 = rst && run_m && (d != 0) && ((d % dv) == 0);
        e1 = e8 && ((d % (8 * dv)) == 0);
        check("tick_8x_timing", longint'(tick_8x), longint'(e8));
        check("tick_1x_timing", longint'(tick_1x), longint'(e1));
        if (tick_1x === 1'b1) begin
            check("tick_1x_implies_8x", longint'(tick_8x), 1);
            check("tick_1x_width", longint'(prev1), 0);
            n1++;
            t1_prev = t1_last;
            t1_last = longint'($time) - 5;
            if (n1 == 1) first1 = t1_last;
        end
        if (tick_8x === 1'b1) begin
            check("tick_8x_width", longint'(prev8), 0);
            n8++;
            t8_prev = t8_last;
            t8_last = longint'($time) - 5;
            if (n8 == 1) first8 = t8_last;
        end
        prev8 = tick_8x;
        prev1 = tick_1x;
    end

    initial begin
        // Scenario 1: held in reset with the fast rate requested
        clear_stats();
        #50;
        check("rst_tick_8x", longint'(tick_8x), 0);
        check("rst_tick_1x", longint'(tick_1x), 0);
        check("rst_div_cnt", longint'(dut.u_div.cnt), 0);
        check("rst_os_cnt", longint'(dut.u_os.cnt), 0);
        check("rst_sel_q", longint'(dut.sel_q), 0);
        #45;
        check("rst_late_tick_8x", longint'(tick_8x), 0);

        // Scenario 2: release at 102 ns, first edge 105 ns, 10000 cycles fast
        #7 rst = 1'b1;
        repeat (10000) @(posedge clk);
        @(negedge clk); #1;
        check("fast_n8", n8, 91);
        check("fast_n1", n1, 11);
        check("fast_first8_time", first8, 1195);
        check("fast_first1_time", first1, 8825);
        check("fast_8x_period", t8_last - t8_prev, 1090);
        check("fast_1x_period", t1_last - t1_prev, 8720);

        // Scenario 3: slow rate selected, short reset pulse, 20900 cycles
        @(negedge clk);
        baud_select = 1'b0;
        #2 rst = 1'b0;
        clear_stats();
        #20 rst = 1'b1;
        @(posedge clk);
        t_e1 = longint'($time);
        repeat (20899) @(posedge clk);
        @(negedge clk); #1;
        check("slow_n8", n8, 16);
        check("slow_n1", n1, 2);
        check("slow_first8_delay", first8 - t_e1, 13020);
        check("slow_first1_delay", first1 - t_e1, 104160);
        check("slow_8x_period", t8_last - t8_prev, 13020);
        check("slow_1x_period", t1_last - t1_prev, 104160);

        // Scenario 4a: slow -> fast mid-period
        count_to_tick(1'b0, 2000, n);
        check("slow_next8_edges", n, 1235);
        repeat (500) @(posedge clk);
        @(negedge clk);
        baud_select = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        check("chg_fast_tick_8x", longint'(tick_8x), 0);
        check("chg_fast_tick_1x", longint'(tick_1x), 0);
        check("chg_fast_div_cnt", longint'(dut.u_div.cnt), 0);
        count_to_tick(1'b0, 2000, n);
        check("chg_fast_first8_edges", n, 109);
        count_to_tick(1'b1, 2000, n);
        check("chg_fast_first1_edges", n, 763);
        check("chg_fast_1x_with_8x", longint'(tick_8x), 1);

        // Scenario 4b: fast -> slow landing on the edge a fast tick was due
        repeat (108) @(posedge clk);
        @(negedge clk);
        baud_select = 1'b0;
        @(posedge clk);
        @(negedge clk); #1;
        check("chg_slow_suppressed_8x", longint'(tick_8x), 0);
        check("chg_slow_suppressed_1x", longint'(tick_1x), 0);
        count_to_tick(1'b0, 3000, n);
        check("chg_slow_first8_edges", n, 1302);

        // Scenario 5: asynchronous reset while tick_8x is high mid-bit
        baud_select = 1'b1;
        count_to_tick(1'b0, 2000, n);
        check("pre_rst_edges", n, 110);
        check("pre_rst_os_cnt", longint'(dut.u_os.cnt), 1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_tick_8x", longint'(tick_8x), 0);
        check("async_rst_tick_1x", longint'(tick_1x), 0);
        check("async_rst_div_cnt", longint'(dut.u_div.cnt), 0);
        check("async_rst_os_cnt", longint'(dut.u_os.cnt), 0);
        check("async_rst_sel_q", longint'(dut.sel_q), 0);
        #9 rst = 1'b1;
        @(posedge clk);
        count_to_tick(1'b0, 2000, n);
        check("rerun_first8_edges", n, 109);
        count_to_tick(1'b1, 2000, n);
        check("rerun_first1_edges", n, 763);
        count_to_tick(1'b0, 2000, n);
        check("rerun_8x_period_edges", n, 109);

        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
